// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 8-bit accumulator CPU: FETCH_OP/DECODE/FETCH_ADDR/READ/EXEC/WRITE/BRANCH.
// Outputs are decoded from state (plus mem_ready for strobes); a low mem_ready stalls the memory states with outputs held.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       c_flag,
  input  logic       z_flag,
  input  logic       n_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_write,
  output logic       ar_write,
  output logic       mdr_write,
  output logic       acc_write,
  output logic       flags_write,
  output logic       acc_src,
  output logic [1:0] alu_op,
  output logic       alu_cin,
  output logic       instr_done,
  output logic       halted,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_START      = 3'd0,
    S_FETCH_OP   = 3'd1,
    S_DECODE     = 3'd2,
    S_FETCH_ADDR = 3'd3,
    S_READ       = 3'd4,
    S_EXEC       = 3'd5,
    S_WRITE      = 3'd6,
    S_BRANCH     = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDA  = 4'b0001;
  localparam logic [3:0] OP_STA  = 4'b0010;
  localparam logic [3:0] OP_JMP  = 4'b0011;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_JC   = 4'b1010;
  localparam logic [3:0] OP_JN   = 4'b1011;
  localparam logic [3:0] OP_RSV0 = 4'b1100;
  localparam logic [3:0] OP_RSV1 = 4'b1101;
  localparam logic [3:0] OP_RSV2 = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  state_t state_q, state_d;
  logic   halt_q, halt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign state_dbg = state_q;
  assign halted    = halt_q;

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    ir_write    = 1'b0;
    ar_write    = 1'b0;
    mdr_write   = 1'b0;
    acc_write   = 1'b0;
    flags_write = 1'b0;
    acc_src     = 1'b0;
    alu_op      = 2'b00;
    alu_cin     = 1'b0;
    instr_done  = 1'b0;

    // HALT shares encoding 7 with BRANCH; the halt bit freezes everything until reset.
    if (!halt_q) begin
      case (state_q)
        S_START: state_d = S_FETCH_OP;

        S_FETCH_OP: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_inc   = 1'b1;
            state_d  = S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_NOP, OP_RSV0, OP_RSV1, OP_RSV2: begin
              instr_done = 1'b1;
              state_d    = S_FETCH_OP;
            end
            OP_NOT:  state_d = S_EXEC;
            OP_HLT: begin
              state_d = S_BRANCH;
              halt_d  = 1'b1;
            end
            default: state_d = S_FETCH_ADDR;
          endcase
        end

        S_FETCH_ADDR: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ar_write = 1'b1;
            pc_inc   = 1'b1;
            case (opcode)
              OP_JMP, OP_JZ, OP_JC, OP_JN: state_d = S_BRANCH;
              OP_STA:                      state_d = S_WRITE;
              default:                     state_d = S_READ;
            endcase
          end
        end

        S_READ: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            state_d   = S_EXEC;
          end
        end

        S_EXEC: begin
          acc_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH_OP;
          case (opcode)
            OP_LDA: acc_src = 1'b1;
            OP_ADC: begin
              flags_write = 1'b1;
              alu_cin     = c_flag;
            end
            OP_SUB: begin
              flags_write = 1'b1;
              alu_op      = 2'b01;
              alu_cin     = 1'b1;
            end
            OP_AND: begin
              flags_write = 1'b1;
              alu_op      = 2'b10;
            end
            OP_NOT: begin
              flags_write = 1'b1;
              alu_op      = 2'b11;
            end
            default: flags_write = 1'b1;
          endcase
        end

        S_WRITE: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH_OP;
          end
        end

        S_BRANCH: begin
          instr_done = 1'b1;
          state_d    = S_FETCH_OP;
          case (opcode)
            OP_JMP:  pc_load = 1'b1;
            OP_JZ:   pc_load = z_flag;
            OP_JC:   pc_load = c_flag;
            OP_JN:   pc_load = n_flag;
            default: pc_load = 1'b0;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: one row per clock cycle, plus async reset sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       c_flag, z_flag, n_flag, mem_ready;
  logic       mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_write, ar_write;
  logic       mdr_write, acc_write, flags_write, acc_src, alu_cin, instr_done, halted;
  logic [1:0] alu_op;
  logic [2:0] state_dbg;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .c_flag(c_flag), .z_flag(z_flag),
    .n_flag(n_flag), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .pc_inc(pc_inc), .pc_load(pc_load), .ir_write(ir_write),
    .ar_write(ar_write), .mdr_write(mdr_write), .acc_write(acc_write),
    .flags_write(flags_write), .acc_src(acc_src), .alu_op(alu_op), .alu_cin(alu_cin),
    .instr_done(instr_done), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {state[2:0], halted, mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_write, ar_write,
  //  mdr_write, acc_write, flags_write, acc_src, alu_op[1:0], alu_cin, instr_done}
  logic [18:0] act;
  assign act = {state_dbg, halted, mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_write,
                ar_write, mdr_write, acc_write, flags_write, acc_src, alu_op, alu_cin, instr_done};

  localparam logic [18:0] B_HALT  = 19'h08000;
  localparam logic [18:0] B_REQ   = 19'h04000;
  localparam logic [18:0] B_WE    = 19'h02000;
  localparam logic [18:0] B_ADDR  = 19'h01000;
  localparam logic [18:0] B_PCINC = 19'h00800;
  localparam logic [18:0] B_PCLD  = 19'h00400;
  localparam logic [18:0] B_IRW   = 19'h00200;
  localparam logic [18:0] B_ARW   = 19'h00100;
  localparam logic [18:0] B_MDRW  = 19'h00080;
  localparam logic [18:0] B_ACCW  = 19'h00040;
  localparam logic [18:0] B_FLW   = 19'h00020;
  localparam logic [18:0] B_SRC   = 19'h00010;
  localparam logic [18:0] B_OPSUB = 19'h00004;
  localparam logic [18:0] B_OPAND = 19'h00008;
  localparam logic [18:0] B_OPNOT = 19'h0000C;
  localparam logic [18:0] B_CIN   = 19'h00002;
  localparam logic [18:0] B_DONE  = 19'h00001;

  localparam logic [18:0] E_START = 19'h00000;
  localparam logic [18:0] E_FETCH = 19'h10000 | B_REQ | B_PCINC | B_IRW;
  localparam logic [18:0] E_FWAIT = 19'h10000 | B_REQ;
  localparam logic [18:0] E_DEC   = 19'h20000;
  localparam logic [18:0] E_ADDR  = 19'h30000 | B_REQ | B_PCINC | B_ARW;
  localparam logic [18:0] E_AWAIT = 19'h30000 | B_REQ;
  localparam logic [18:0] E_READ  = 19'h40000 | B_REQ | B_ADDR | B_MDRW;
  localparam logic [18:0] E_RWAIT = 19'h40000 | B_REQ | B_ADDR;
  localparam logic [18:0] E_EXEC  = 19'h50000 | B_ACCW | B_DONE;
  localparam logic [18:0] E_WWAIT = 19'h60000 | B_REQ | B_WE | B_ADDR;
  localparam logic [18:0] E_BR    = 19'h70000 | B_DONE;
  localparam logic [18:0] E_HALT  = 19'h70000 | B_HALT;

  typedef struct {
    logic [3:0]  op;
    logic        rdy;
    logic [2:0]  czn;
    logic [18:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic [3:0] op, input logic rdy, input logic [2:0] czn,
                     input logic [18:0] e, input string nm);
    vec_t v;
    v.op = op; v.rdy = rdy; v.czn = czn; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  // Zero-wait two-byte instruction through READ into EXEC.
  task automatic add_rd(input logic [3:0] op, input logic [2:0] czn,
                        input logic [18:0] ex, input string nm);
    add(op, 1'b1, czn, E_FETCH, {nm, "_fetch"});
    add(op, 1'b1, czn, E_DEC,   {nm, "_decode"});
    add(op, 1'b1, czn, E_ADDR,  {nm, "_faddr"});
    add(op, 1'b1, czn, E_READ,  {nm, "_read"});
    add(op, 1'b1, czn, ex,      {nm, "_exec"});
  endtask

  task automatic add_br(input logic [3:0] op, input logic [2:0] czn,
                        input logic [18:0] ex, input string nm);
    add(op, 1'b1, czn, E_FETCH, {nm, "_fetch"});
    add(op, 1'b1, czn, E_DEC,   {nm, "_decode"});
    add(op, 1'b1, czn, E_ADDR,  {nm, "_faddr"});
    add(op, 1'b1, czn, ex,      {nm, "_branch"});
  endtask

  task automatic check(input string nm, input logic [18:0] a, input logic [18:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", nm, a, e);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run(input vec_t v);
    opcode    = v.op;
    mem_ready = v.rdy;
    {c_flag, z_flag, n_flag} = v.czn;
    @(negedge clk);
    check(v.name, act, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'h0; mem_ready = 1'b0;
    c_flag = 1'b0; z_flag = 1'b0; n_flag = 1'b0;

    // NOP, including a ready that must be ignored while mem_req is low
    add(4'h0, 1'b1, 3'b000, E_START, "nop_start");
    add(4'h0, 1'b1, 3'b000, E_FETCH, "nop_fetch");
    add(4'h0, 1'b0, 3'b000, E_DEC | B_DONE, "nop_decode");
    add_rd(4'h4, 3'b000, E_EXEC | B_FLW, "add");
    add_rd(4'h6, 3'b000, E_EXEC | B_FLW | B_OPSUB | B_CIN, "sub");
    add_rd(4'h5, 3'b100, E_EXEC | B_FLW | B_CIN, "adc_c1");
    add_rd(4'h5, 3'b011, E_EXEC | B_FLW, "adc_c0");
    add_rd(4'h7, 3'b111, E_EXEC | B_FLW | B_OPAND, "and");
    add_rd(4'h1, 3'b000, E_EXEC | B_SRC, "lda");
    // NOT: three cycles, no address fetch
    add(4'h8, 1'b1, 3'b000, E_FETCH, "not_fetch");
    add(4'h8, 1'b1, 3'b000, E_DEC, "not_decode");
    add(4'h8, 1'b1, 3'b000, E_EXEC | B_FLW | B_OPNOT, "not_exec");
    add(4'hD, 1'b1, 3'b000, E_FETCH, "rsv_fetch");
    add(4'hD, 1'b1, 3'b000, E_DEC | B_DONE, "rsv_decode");
    // STA with a fetch stall, address stall and three-cycle write stall
    add(4'h2, 1'b0, 3'b000, E_FWAIT, "sta_fwait");
    add(4'h2, 1'b1, 3'b000, E_FETCH, "sta_fetch");
    add(4'h2, 1'b1, 3'b000, E_DEC, "sta_decode");
    add(4'h2, 1'b0, 3'b000, E_AWAIT, "sta_await");
    add(4'h2, 1'b1, 3'b000, E_ADDR, "sta_faddr");
    add(4'h2, 1'b0, 3'b000, E_WWAIT, "sta_wwait0");
    add(4'h2, 1'b0, 3'b000, E_WWAIT, "sta_wwait1");
    add(4'h2, 1'b0, 3'b000, E_WWAIT, "sta_wwait2");
    add(4'h2, 1'b1, 3'b000, E_WWAIT | B_DONE, "sta_write");
    // LDA with a READ stall
    add(4'h1, 1'b1, 3'b000, E_FETCH, "ldaw_fetch");
    add(4'h1, 1'b1, 3'b000, E_DEC, "ldaw_decode");
    add(4'h1, 1'b1, 3'b000, E_ADDR, "ldaw_faddr");
    add(4'h1, 1'b0, 3'b000, E_RWAIT, "ldaw_rwait");
    add(4'h1, 1'b1, 3'b000, E_READ, "ldaw_read");
    add(4'h1, 1'b1, 3'b000, E_EXEC | B_SRC, "ldaw_exec");
    // Branches: flags only matter in BRANCH
    add_br(4'h9, 3'b000, E_BR, "jz_nt");
    add_br(4'h9, 3'b010, E_BR | B_PCLD, "jz_t");
    add_br(4'h3, 3'b000, E_BR | B_PCLD, "jmp");
    add_br(4'hA, 3'b100, E_BR | B_PCLD, "jc_t");
    add_br(4'hA, 3'b011, E_BR, "jc_nt");
    add_br(4'hB, 3'b001, E_BR | B_PCLD, "jn_t");
    add_br(4'hB, 3'b110, E_BR, "jn_nt");
    // HLT, then inputs wiggle while halted
    add(4'hF, 1'b1, 3'b000, E_FETCH, "hlt_fetch");
    add(4'hF, 1'b1, 3'b000, E_DEC, "hlt_decode");
    add(4'hF, 1'b1, 3'b111, E_HALT, "halt0");
    add(4'h0, 1'b0, 3'b111, E_HALT, "halt1");
    add(4'h8, 1'b1, 3'b000, E_HALT, "halt2");
    add(4'h3, 1'b0, 3'b010, E_HALT, "halt3");

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", act, E_START);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (tbl[i]) run(tbl[i]);

    // Asynchronous reset out of HALT
    rst_n = 1'b0;
    #1;
    check("rst_from_halt", act, E_START);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tbl.delete();
    add(4'h1, 1'b1, 3'b000, E_START, "r2_start");
    add(4'h1, 1'b1, 3'b000, E_FETCH, "r2_fetch");
    add(4'h1, 1'b1, 3'b000, E_DEC, "r2_decode");
    add(4'h1, 1'b1, 3'b000, E_ADDR, "r2_faddr");
    add(4'h1, 1'b0, 3'b000, E_RWAIT, "r2_rwait");
    foreach (tbl[i]) run(tbl[i]);

    // Asynchronous reset mid-READ with mem_ready now high: no mdr_write may fire
    mem_ready = 1'b1;
    #1;
    check("mid_read_pre", act, E_READ);
    rst_n = 1'b0;
    #1;
    check("rst_mid_read", act, E_START);
    @(posedge clk);
    @(negedge clk);
    check("rst_held", act, E_START);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tbl.delete();
    add(4'h0, 1'b1, 3'b000, E_START, "r3_start");
    add(4'h0, 1'b1, 3'b000, E_FETCH, "r3_fetch");
    add(4'h0, 1'b1, 3'b000, E_DEC | B_DONE, "r3_decode");
    add(4'h0, 1'b1, 3'b000, E_FETCH, "r3_fetch2");
    foreach (tbl[i]) run(tbl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the 8-bit accumulator processor. It sequences instruction fetch, operand fetch, execute and store over a single shared 8-bit memory port with a ready handshake. It drives the register-enable and mux-select lines of the datapath (PC, IR, AR, MDR, ACC, flags) and the 2-bit ALU operation. It sits between the instruction register's opcode field and the datapath, replacing hard-wired single-cycle decode.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  IR[7:4], valid from the cycle after ir_write
- c_flag, z_flag, n_flag  in  1 each  flag-register outputs
- mem_ready  in  1  memory completes the current access when high at a clk edge with mem_req high
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write ACC to memory, 0 = read
- addr_sel  out  1  memory address: 0 = PC, 1 = AR
- pc_inc, pc_load, ir_write, ar_write, mdr_write, acc_write, flags_write  out  1 each  datapath load strobes
- acc_src  out  1  ACC input: 0 = ALU, 1 = MDR
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT
- alu_cin  out  1  ALU carry-in
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- halted  out  1  high in HALT
- state_dbg  out  3  current state encoding

## Operation
- ISA: 1-byte instructions are opcode only; 2-byte instructions carry an address in byte 2.
  - 1-byte: 0000 NOP, 1000 NOT, 1111 HLT, 1100–1110 reserved (execute as NOP).
  - 2-byte: 0001 LDA, 0010 STA, 0011 JMP, 0100 ADD, 0101 ADC, 0110 SUB, 0111 AND, 1001 JZ, 1010 JC, 1011 JN.
- Outputs are decoded from state, plus mem_ready for the strobes. Every output not listed for a state is 0.
- State encoding and behaviour:
  - START (0): all outputs 0; next state is FETCH_OP.
  - FETCH_OP (1): mem_req=1, addr_sel=0. When mem_ready is high: ir_write=1, pc_inc=1, next state is DECODE. Otherwise stay.
  - DECODE (2):
    - NOP or reserved: instr_done=1, next state FETCH_OP.
    - NOT: next state EXEC.
    - HLT: next state HALT.
    - All others: next state FETCH_ADDR.
  - FETCH_ADDR (3): mem_req=1, addr_sel=0. When mem_ready is high: ar_write=1, pc_inc=1, then branch on opcode:
    - JMP/JZ/JC/JN: next state BRANCH.
    - STA: next state WRITE.
    - All others: next state READ.
  - READ (4): mem_req=1, addr_sel=1. When mem_ready is high: mdr_write=1, next state EXEC.
  - EXEC (5): acc_write=1, instr_done=1, next state FETCH_OP.
    - LDA: acc_src=1, flags_write=0.
    - ALU ops: acc_src=0, flags_write=1, alu_op from opcode. ADD/ADC = 00, SUB = 01, AND = 10, NOT = 11.
    - alu_cin = c_flag for ADC, 1 for SUB (two's complement), 0 otherwise.
  - WRITE (6): mem_req=1, mem_we=1, addr_sel=1. When mem_ready is high: instr_done=1, next state FETCH_OP.
  - BRANCH (7): pc_load=1 if JMP, or JZ with z_flag, or JC with c_flag, or JN with n_flag. instr_done=1 in all cases; next state FETCH_OP.
  - HALT: reuses encoding 7 with halted=1. Use an internal halt bit: state_dbg=7 and halted=1. All strobes are 0. Only reset leaves HALT.
- mem_ready is ignored whenever mem_req=0.
- The opcode is re-sampled in every state. The IR is stable after FETCH_OP, so no internal opcode latch is needed.

## Timing
- Reset (asynchronous, any state, including mid-memory access): state=START, halted=0, all outputs 0 immediately.
  - The first mem_req is asserted in the second clk edge's cycle after rst_n rises.
  - An access that was pending at reset is abandoned; no strobe fires.
- Cycle counts with zero wait states (mem_ready held high):
  - NOP/reserved: 2
  - NOT: 3
  - JMP/Jcc, taken or not: 4
  - STA: 4
  - LDA/ADD/ADC/SUB/AND: 5
  - HLT: 2 cycles to reach HALT
- Each low cycle of mem_ready adds exactly one cycle and holds all outputs constant.
- Strobes accompanying mem_ready are single-cycle. No strobe repeats while stalled.
- Flag inputs are sampled in EXEC/BRANCH only. A flags_write in EXEC affects the next instruction's branch, not the current one.

## Test plan
- Reset then zero-wait NOP: mem_req=0 for 1 cycle after reset release. Then FETCH_OP→DECODE→FETCH_OP, with instr_done high in cycle 3 and pc_inc pulsed once.
- ADD with mem_ready=1: state_dbg sequence 1,2,3,4,5. pc_inc pulses twice, mdr_write once. In EXEC: acc_write=1, acc_src=0, alu_op=00, alu_cin=0, flags_write=1.
- SUB, ADC with c_flag=1, AND, NOT: alu_op/alu_cin are 01/1, 00/1, 10/0, 11/0 respectively. NOT takes 3 cycles and never asserts ar_write.
- STA with mem_ready low for 3 cycles in WRITE: mem_req=mem_we=addr_sel=1 held for 4 cycles. instr_done fires once, in the mem_ready cycle.
- JZ with z_flag=0, then z_flag=1: pc_load=0, then pc_load=1. Both take 4 cycles.
- HLT, then toggle mem_ready and opcode: halted=1 and all strobes stay 0. Asserting rst_n=0 mid-READ clears to START, with halted=0 and mem_req=0 asynchronously.
